// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer
// Accepts one register command at a time over a valid/ready handshake and
// expands it into single-cycle one-hot LOAD/INC/DEC/CLR strobes for a bank of
// NREG registers. Multi-step commands (repeat INC/DEC, LOAD_INC) issue one
// strobe per clock. DONE/ERR are one-cycle pulses in the FIN state.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   CMD_VALID/READY     command handshake
//   CMD_OP/SEL/DATA/REP opcode, target index, load value, repeat count
//   ABORT               stop an in-progress command (sampled in ISSUE only)
//   REG_DATA            load value held from the last accepted command
//   REG_LOAD/INC/DEC/CLR one-hot strobes to the register bank
//   BUSY, DONE, ERR     status
module reg_cmd_sequencer #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned NREG   = 4,
  parameter int unsigned REP_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [2:0]                CMD_OP,
  input  logic [$clog2(NREG)-1:0]   CMD_SEL,
  input  logic [DATA_W-1:0]         CMD_DATA,
  input  logic [REP_W-1:0]          CMD_REP,
  input  logic                      ABORT,
  output logic [DATA_W-1:0]         REG_DATA,
  output logic [NREG-1:0]           REG_LOAD,
  output logic [NREG-1:0]           REG_INC,
  output logic [NREG-1:0]           REG_DEC,
  output logic [NREG-1:0]           REG_CLR,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR
);

  localparam int unsigned SelW = $clog2(NREG);

  localparam logic [2:0] OpNop     = 3'b000;
  localparam logic [2:0] OpLoad    = 3'b001;
  localparam logic [2:0] OpInc     = 3'b010;
  localparam logic [2:0] OpDec     = 3'b011;
  localparam logic [2:0] OpClr     = 3'b100;
  localparam logic [2:0] OpLoadInc = 3'b101;

  typedef enum logic [1:0] {StIdle, StIssue, StFin} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REP_W-1:0]  cnt_q, cnt_d;
  // LOAD_INC: high while the leading LOAD strobe is still to be issued
  logic              load_ph_q, load_ph_d;
  // ERR to be reported in FIN (illegal opcode or abort)
  logic              err_q, err_d;

  logic              illegal_op;
  logic [NREG-1:0]   sel_onehot;

  assign illegal_op = (CMD_OP[2:1] == 2'b11);
  assign sel_onehot = NREG'(1) << sel_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      sel_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      load_ph_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      load_ph_q <= load_ph_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    load_ph_d = load_ph_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          op_d      = CMD_OP;
          sel_d     = CMD_SEL;
          data_d    = CMD_DATA;
          cnt_d     = (CMD_REP == '0) ? REP_W'(1) : CMD_REP;
          load_ph_d = (CMD_OP == OpLoadInc);
          err_d     = illegal_op;
          state_d   = (illegal_op || CMD_OP == OpNop) ? StFin : StIssue;
        end
      end
      StIssue: begin
        if (ABORT) begin
          // The strobe already driven this cycle still counts as issued
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          unique case (op_q)
            OpInc, OpDec: begin
              if (cnt_q == REP_W'(1)) state_d = StFin;
              else                    cnt_d   = cnt_q - REP_W'(1);
            end
            OpLoadInc: begin
              if (load_ph_q)                load_ph_d = 1'b0;
              else if (cnt_q == REP_W'(1))  state_d   = StFin;
              else                          cnt_d     = cnt_q - REP_W'(1);
            end
            default: state_d = StFin;  // LOAD, CLR: single strobe
          endcase
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only; no path from CMD_* inputs.
  always_comb begin
    REG_LOAD = '0;
    REG_INC  = '0;
    REG_DEC  = '0;
    REG_CLR  = '0;
    if (state_q == StIssue) begin
      unique case (op_q)
        OpLoad:    REG_LOAD = sel_onehot;
        OpInc:     REG_INC  = sel_onehot;
        OpDec:     REG_DEC  = sel_onehot;
        OpClr:     REG_CLR  = sel_onehot;
        OpLoadInc: begin
          if (load_ph_q) REG_LOAD = sel_onehot;
          else           REG_INC  = sel_onehot;
        end
        default: ;
      endcase
    end
  end

  assign REG_DATA  = data_q;
  assign CMD_READY = (state_q == StIdle);
  assign BUSY      = (state_q != StIdle);
  assign DONE      = (state_q == StFin);
  assign ERR       = (state_q == StFin) && err_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer. Each command pushes its expected
// per-cycle output records to a scoreboard queue; records are popped and
// compared on the falling edge of each following cycle.
module tb_reg_cmd_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_OP;
  logic [1:0]  CMD_SEL;
  logic [18:0] CMD_DATA;
  logic [7:0]  CMD_REP;
  logic        ABORT;
  logic [18:0] REG_DATA;
  logic [3:0]  REG_LOAD, REG_INC, REG_DEC, REG_CLR;
  logic        BUSY, DONE, ERR;

  reg_cmd_sequencer #(.DATA_W(19), .NREG(4), .REP_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_SEL   (CMD_SEL),
    .CMD_DATA  (CMD_DATA),
    .CMD_REP   (CMD_REP),
    .ABORT     (ABORT),
    .REG_DATA  (REG_DATA),
    .REG_LOAD  (REG_LOAD),
    .REG_INC   (REG_INC),
    .REG_DEC   (REG_DEC),
    .REG_CLR   (REG_CLR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // strb = {LOAD, INC, DEC, CLR}; flags = {DONE, ERR, BUSY, READY}
  typedef struct packed {
    logic [15:0] strb;
    logic [3:0]  flags;
    logic [18:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Downstream register bank driven by the DUT strobes
  logic [18:0] regs [4];
  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (REG_CLR[i])       regs[i] <= '0;
      else if (REG_LOAD[i]) regs[i] <= REG_DATA;
      else if (REG_INC[i])  regs[i] <= regs[i] + 19'd1;
      else if (REG_DEC[i])  regs[i] <= regs[i] - 19'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [1:0] sel, input logic [18:0] data,
                          input int rep, input int abort_at);
    int k, s, rep_eff;
    logic ill, ab;
    logic [3:0] oh;
    exp_t e;
    ill     = (op[2:1] == 2'b11);
    rep_eff = (rep == 0) ? 1 : rep;
    oh      = 4'b0001 << sel;
    case (op)
      3'd1, 3'd4: k = 1;
      3'd2, 3'd3: k = rep_eff;
      3'd5:       k = 1 + rep_eff;
      default:    k = 0;
    endcase
    ab = (abort_at != 0) && (abort_at <= k);
    s  = ab ? abort_at : k;
    for (int i = 1; i <= s; i++) begin
      if (op == 3'd1 || (op == 3'd5 && i == 1)) e.strb = {oh, 12'h000};
      else if (op == 3'd2 || op == 3'd5)       e.strb = {4'h0, oh, 8'h00};
      else if (op == 3'd3)                     e.strb = {8'h00, oh, 4'h0};
      else                                     e.strb = {12'h000, oh};
      e.flags = 4'b0010;
      e.data  = data;
      sb.push_back(e);
    end
    e.strb  = '0;
    e.flags = {1'b1, ill | ab, 1'b1, 1'b0};
    e.data  = data;
    sb.push_back(e);
    e.flags = 4'b0001;
    sb.push_back(e);
  endtask

  // Called at #1 after a rising edge with the DUT idle. Returns at #1 after
  // the rising edge following the last compared cycle.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [1:0] sel,
                         input logic [18:0] data, input int rep, input int abort_at,
                         input int stop_at);
    exp_t e;
    int   c;
    CMD_OP    = op;
    CMD_SEL   = sel;
    CMD_DATA  = data;
    CMD_REP   = 8'(rep);
    CMD_VALID = 1'b1;
    push_cmd(op, sel, data, rep, abort_at);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_OP    = $urandom_range(7, 0);  // must be ignored outside IDLE
    c = 1;
    while (sb.size() > 0 && (stop_at == 0 || c <= stop_at)) begin
      ABORT = (c == abort_at);
      @(negedge CLK);
      e = sb.pop_front();
      check($sformatf("%s c%0d strobes", name, c),
            64'({REG_LOAD, REG_INC, REG_DEC, REG_CLR}), 64'(e.strb));
      check($sformatf("%s c%0d flags", name, c),
            64'({DONE, ERR, BUSY, CMD_READY}), 64'(e.flags));
      check($sformatf("%s c%0d data", name, c), 64'(REG_DATA), 64'(e.data));
      @(posedge CLK);
      #1;
      c++;
    end
    ABORT = 1'b0;
    sb.delete();
  endtask

  initial begin
    RST_N     = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP    = '0;
    CMD_SEL   = '0;
    CMD_DATA  = '0;
    CMD_REP   = '0;
    ABORT     = 1'b0;
    for (int i = 0; i < 4; i++) regs[i] = '0;

    repeat (2) @(negedge CLK);
    check("reset strobes", 64'({REG_LOAD, REG_INC, REG_DEC, REG_CLR}), 64'(0));
    check("reset flags", 64'({DONE, ERR, BUSY, CMD_READY}), 64'(4'b0001));
    check("reset data", 64'(REG_DATA), 64'(0));
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    run_cmd("load", 3'd1, 2'd2, 19'h5A5A5, 7, 0, 0);
    run_cmd("inc3", 3'd2, 2'd1, 19'h00123, 3, 0, 0);
    run_cmd("inc0", 3'd2, 2'd1, 19'h00456, 0, 0, 0);
    run_cmd("ldinc", 3'd5, 2'd0, 19'h7FFFF, 2, 0, 0);
    check("ldinc wrap", 64'(regs[0]), 64'(19'h00001));
    run_cmd("dec_abort", 3'd3, 2'd3, 19'h00010, 10, 4, 0);
    run_cmd("illegal", 3'd6, 2'd1, 19'h11111, 5, 0, 0);
    run_cmd("nop", 3'd0, 2'd2, 19'h22222, 5, 0, 0);
    run_cmd("dec2", 3'd3, 2'd2, 19'h33333, 2, 0, 0);
    check("bank reg2", 64'(regs[2]), 64'(19'h5A5A3));

    // Reset asserted in cycle 20 of a 50-strobe INC
    run_cmd("inc50", 3'd2, 2'd1, 19'h0ABCD, 50, 0, 19);
    RST_N = 1'b0;
    #2;
    check("midrst strobes", 64'({REG_LOAD, REG_INC, REG_DEC, REG_CLR}), 64'(0));
    check("midrst flags", 64'({DONE, ERR, BUSY, CMD_READY}), 64'(4'b0001));
    check("midrst data", 64'(REG_DATA), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    run_cmd("clr", 3'd4, 2'd1, 19'h44444, 9, 0, 0);
    check("clr reg1", 64'(regs[1]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
